// File: rtl/rs_alu.sv
// rs_alu: reservation station in front of the integer ALU.
//
// Holds dispatched ALU/branch/jump instructions until both source operands
// are known, snooping the ALU and LSB common data buses for pending
// operands, and issues one ready instruction per cycle as registered
// operand fields that drive the combinational ALU directly.
//
// Optional feature (compile-time macro RS_ALU_OLDEST_FIRST_EN):
//   defined   - each entry carries a dispatch age stamp; issue picks the
//               oldest ready entry (stamp compared modulo wrap).
//   undefined - issue picks the lowest-index ready entry.
//
// Handshake: a dispatch transfers at a rising clk_in edge when
//   disp_valid && rdy_in && !flush_in && !rs_full. While rs_full is high the
//   request is ignored and upstream must hold it. rs_full is combinational
//   from the entry valid bits and is evaluated before that edge's issue.
//
// Ports:
//   clk_in, rst_in (async, active-low), rdy_in (global stall), flush_in
//   disp_*        : dispatch request and decoded instruction fields
//   cdb_alu_*     : ALU result broadcast (valid, alias, value)
//   cdb_lsb_*     : LSB result broadcast (valid, alias, value)
//   rs_full       : no free entry
//   alu_*         : registered issue fields; alu_optype = 0 (NOP) when idle
module rs_alu #(
   parameter int RS_SIZE  = 16,
   parameter int OPTYPE_W = 6,
   parameter int ROB_ID_W = 4,
   parameter int XLEN     = 32
) (
   input  logic                clk_in,
   input  logic                rst_in,
   input  logic                rdy_in,
   input  logic                flush_in,
   input  logic                disp_valid,
   input  logic [OPTYPE_W-1:0] disp_optype,
   input  logic [ROB_ID_W-1:0] disp_rd_alias,
   input  logic [XLEN-1:0]     disp_pc,
   input  logic [XLEN-1:0]     disp_imm,
   input  logic                disp_q1_busy,
   input  logic [ROB_ID_W-1:0] disp_q1,
   input  logic [XLEN-1:0]     disp_v1,
   input  logic                disp_q2_busy,
   input  logic [ROB_ID_W-1:0] disp_q2,
   input  logic [XLEN-1:0]     disp_v2,
   input  logic                cdb_alu_valid,
   input  logic [ROB_ID_W-1:0] cdb_alu_alias,
   input  logic [XLEN-1:0]     cdb_alu_value,
   input  logic                cdb_lsb_valid,
   input  logic [ROB_ID_W-1:0] cdb_lsb_alias,
   input  logic [XLEN-1:0]     cdb_lsb_value,
   output logic                rs_full,
   output logic [OPTYPE_W-1:0] alu_optype,
   output logic [ROB_ID_W-1:0] alu_rd_alias,
   output logic [XLEN-1:0]     alu_pc,
   output logic [XLEN-1:0]     alu_rs1,
   output logic [XLEN-1:0]     alu_rs2,
   output logic [XLEN-1:0]     alu_imm
);

   localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

   // Entry storage
   logic [RS_SIZE-1:0]  valid;
   logic [RS_SIZE-1:0]  q1_busy;
   logic [RS_SIZE-1:0]  q2_busy;
   logic [OPTYPE_W-1:0] optype   [RS_SIZE];
   logic [ROB_ID_W-1:0] rd_alias [RS_SIZE];
   logic [XLEN-1:0]     pc       [RS_SIZE];
   logic [XLEN-1:0]     imm      [RS_SIZE];
   logic [ROB_ID_W-1:0] q1       [RS_SIZE];
   logic [ROB_ID_W-1:0] q2       [RS_SIZE];
   logic [XLEN-1:0]     v1       [RS_SIZE];
   logic [XLEN-1:0]     v2       [RS_SIZE];

`ifdef RS_ALU_OLDEST_FIRST_EN
   localparam int AGE_W = IDX_W + 1;
   logic [AGE_W-1:0] age [RS_SIZE];
   logic [AGE_W-1:0] age_cnt;

   // a is older than b when (a - b) wraps negative.
   function automatic logic is_older(input logic [AGE_W-1:0] a,
                                     input logic [AGE_W-1:0] b);
      logic [AGE_W-1:0] diff;
      diff = a - b;
      return diff[AGE_W-1];
   endfunction
`endif

   // Resolve one operand against both CDBs: returns {busy, value}.
   // The ALU bus wins if both match (aliases are unique by protocol).
   function automatic logic [XLEN:0] resolve(input logic                busy,
                                             input logic [ROB_ID_W-1:0] q,
                                             input logic [XLEN-1:0]     v);
      logic [XLEN:0] r;
      r = {busy, v};
      if (busy) begin
         if (cdb_alu_valid && (cdb_alu_alias == q))
            r = {1'b0, cdb_alu_value};
         else if (cdb_lsb_valid && (cdb_lsb_alias == q))
            r = {1'b0, cdb_lsb_value};
      end
      return r;
   endfunction

   logic [RS_SIZE-1:0] ready;
   logic               free_found;
   logic [IDX_W-1:0]   free_idx;
   logic               iss_found;
   logic [IDX_W-1:0]   iss_idx;
   logic               disp_fire;
   logic [XLEN:0]      disp_op1;
   logic [XLEN:0]      disp_op2;

   assign rs_full   = &valid;
   assign ready     = valid & ~q1_busy & ~q2_busy;
   assign disp_fire = disp_valid && rdy_in && !flush_in && !rs_full;
   assign disp_op1  = resolve(disp_q1_busy, disp_q1, disp_v1);
   assign disp_op2  = resolve(disp_q2_busy, disp_q2, disp_v2);

   // Lowest-index free slot
   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = 0; i < RS_SIZE; i++) begin
         if (!valid[i] && !free_found) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
         end
      end
   end

   // Issue selection over entries ready before this edge's wakeup, so a
   // freshly woken entry issues one cycle later.
   always_comb begin
      iss_found = 1'b0;
      iss_idx   = '0;
      for (int i = 0; i < RS_SIZE; i++) begin
`ifdef RS_ALU_OLDEST_FIRST_EN
         if (ready[i] && (!iss_found || is_older(age[i], age[iss_idx]))) begin
`else
         if (ready[i] && !iss_found) begin
`endif
            iss_found = 1'b1;
            iss_idx   = IDX_W'(i);
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         valid        <= '0;
         q1_busy      <= '0;
         q2_busy      <= '0;
         alu_optype   <= '0;
         alu_rd_alias <= '0;
         alu_pc       <= '0;
         alu_rs1      <= '0;
         alu_rs2      <= '0;
         alu_imm      <= '0;
         for (int i = 0; i < RS_SIZE; i++) begin
            optype[i]   <= '0;
            rd_alias[i] <= '0;
            pc[i]       <= '0;
            imm[i]      <= '0;
            q1[i]       <= '0;
            q2[i]       <= '0;
            v1[i]       <= '0;
            v2[i]       <= '0;
`ifdef RS_ALU_OLDEST_FIRST_EN
            age[i]      <= '0;
`endif
         end
`ifdef RS_ALU_OLDEST_FIRST_EN
         age_cnt <= '0;
`endif
      end else if (flush_in) begin
         valid      <= '0;
         alu_optype <= '0;
`ifdef RS_ALU_OLDEST_FIRST_EN
         age_cnt    <= '0;
`endif
      end else if (rdy_in) begin
         // Wakeup
         for (int i = 0; i < RS_SIZE; i++) begin
            if (valid[i]) begin
               {q1_busy[i], v1[i]} <= resolve(q1_busy[i], q1[i], v1[i]);
               {q2_busy[i], v2[i]} <= resolve(q2_busy[i], q2[i], v2[i]);
            end
         end
         // Issue
         if (iss_found) begin
            valid[iss_idx] <= 1'b0;
            alu_optype     <= optype[iss_idx];
            alu_rd_alias   <= rd_alias[iss_idx];
            alu_pc         <= pc[iss_idx];
            alu_rs1        <= v1[iss_idx];
            alu_rs2        <= v2[iss_idx];
            alu_imm        <= imm[iss_idx];
         end else begin
            alu_optype <= '0;
         end
         // Dispatch into a slot that was free before this edge
         if (disp_fire) begin
            valid[free_idx]    <= 1'b1;
            optype[free_idx]   <= disp_optype;
            rd_alias[free_idx] <= disp_rd_alias;
            pc[free_idx]       <= disp_pc;
            imm[free_idx]      <= disp_imm;
            q1[free_idx]       <= disp_q1;
            q2[free_idx]       <= disp_q2;
            {q1_busy[free_idx], v1[free_idx]} <= disp_op1;
            {q2_busy[free_idx], v2[free_idx]} <= disp_op2;
`ifdef RS_ALU_OLDEST_FIRST_EN
            age[free_idx] <= age_cnt;
            age_cnt       <= age_cnt + AGE_W'(1);
`endif
         end
      end
   end

endmodule

// File: tb/tb_rs_alu.sv
// tb_rs_alu: directed bench for rs_alu with an issue scoreboard.
// Expected issue packets {optype, rd_alias, pc, rs1, rs2, imm} are queued
// when stimulus is driven and compared whenever alu_optype is non-NOP.
module tb_rs_alu;

   localparam int OPTYPE_W = 6;
   localparam int ROB_ID_W = 4;
   localparam int XLEN     = 32;
   localparam int PKT_W    = OPTYPE_W + ROB_ID_W + 4 * XLEN;

   localparam logic [OPTYPE_W-1:0] OP_ADD  = 6'd1;
   localparam logic [OPTYPE_W-1:0] OP_SUB  = 6'd2;
   localparam logic [OPTYPE_W-1:0] OP_ADDI = 6'd3;
   localparam logic [OPTYPE_W-1:0] OP_OR   = 6'd4;
   localparam logic [OPTYPE_W-1:0] OP_XOR  = 6'd5;
   localparam logic [OPTYPE_W-1:0] OP_AND  = 6'd7;
   localparam logic [OPTYPE_W-1:0] OP_SLT  = 6'd8;

   logic                clk_in = 1'b0;
   logic                rst_in;
   logic                rdy_in;
   logic                flush_in;
   logic                disp_valid;
   logic [OPTYPE_W-1:0] disp_optype;
   logic [ROB_ID_W-1:0] disp_rd_alias;
   logic [XLEN-1:0]     disp_pc;
   logic [XLEN-1:0]     disp_imm;
   logic                disp_q1_busy;
   logic [ROB_ID_W-1:0] disp_q1;
   logic [XLEN-1:0]     disp_v1;
   logic                disp_q2_busy;
   logic [ROB_ID_W-1:0] disp_q2;
   logic [XLEN-1:0]     disp_v2;
   logic                cdb_alu_valid;
   logic [ROB_ID_W-1:0] cdb_alu_alias;
   logic [XLEN-1:0]     cdb_alu_value;
   logic                cdb_lsb_valid;
   logic [ROB_ID_W-1:0] cdb_lsb_alias;
   logic [XLEN-1:0]     cdb_lsb_value;
   logic                rs_full;
   logic [OPTYPE_W-1:0] alu_optype;
   logic [ROB_ID_W-1:0] alu_rd_alias;
   logic [XLEN-1:0]     alu_pc;
   logic [XLEN-1:0]     alu_rs1;
   logic [XLEN-1:0]     alu_rs2;
   logic [XLEN-1:0]     alu_imm;

   int n_checks = 0;
   int n_fail   = 0;
   logic [PKT_W-1:0] exp_q[$];

   rs_alu #(.RS_SIZE(16), .OPTYPE_W(OPTYPE_W), .ROB_ID_W(ROB_ID_W), .XLEN(XLEN)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
      .disp_valid(disp_valid), .disp_optype(disp_optype), .disp_rd_alias(disp_rd_alias),
      .disp_pc(disp_pc), .disp_imm(disp_imm),
      .disp_q1_busy(disp_q1_busy), .disp_q1(disp_q1), .disp_v1(disp_v1),
      .disp_q2_busy(disp_q2_busy), .disp_q2(disp_q2), .disp_v2(disp_v2),
      .cdb_alu_valid(cdb_alu_valid), .cdb_alu_alias(cdb_alu_alias), .cdb_alu_value(cdb_alu_value),
      .cdb_lsb_valid(cdb_lsb_valid), .cdb_lsb_alias(cdb_lsb_alias), .cdb_lsb_value(cdb_lsb_value),
      .rs_full(rs_full), .alu_optype(alu_optype), .alu_rd_alias(alu_rd_alias),
      .alu_pc(alu_pc), .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_imm(alu_imm)
   );

   // Clock
   always #5 clk_in = ~clk_in;

   // Checking
   task automatic check(input string tag, input logic [PKT_W-1:0] got,
                        input logic [PKT_W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic chk_op(input string tag, input logic [OPTYPE_W-1:0] e);
      check(tag, PKT_W'(alu_optype), PKT_W'(e));
   endtask

   task automatic chk_full(input string tag, input logic e);
      check(tag, PKT_W'(rs_full), PKT_W'(e));
   endtask

   function automatic logic [PKT_W-1:0] mk_pkt(input logic [OPTYPE_W-1:0] op,
                                               input logic [ROB_ID_W-1:0] rd,
                                               input logic [XLEN-1:0] pc,
                                               input logic [XLEN-1:0] rs1,
                                               input logic [XLEN-1:0] rs2,
                                               input logic [XLEN-1:0] imm);
      return {op, rd, pc, rs1, rs2, imm};
   endfunction

   // One clock edge, then sample and run the scoreboard.
   task automatic step();
      @(posedge clk_in);
      #1;
      if (alu_optype !== '0) begin
         if (exp_q.size() > 0)
            check("sb_issue", {alu_optype, alu_rd_alias, alu_pc, alu_rs1, alu_rs2, alu_imm},
                  exp_q.pop_front());
         else
            check("sb_spurious", PKT_W'(alu_optype), '0);
      end
   endtask

   // Driver tasks
   task automatic idle_inputs();
      disp_valid    = 1'b0;
      flush_in      = 1'b0;
      cdb_alu_valid = 1'b0;
      cdb_lsb_valid = 1'b0;
   endtask

   task automatic drive_disp(input logic [OPTYPE_W-1:0] op, input logic [ROB_ID_W-1:0] rd,
                             input logic [XLEN-1:0] pc, input logic [XLEN-1:0] imm,
                             input logic b1, input logic [ROB_ID_W-1:0] q1, input logic [XLEN-1:0] v1,
                             input logic b2, input logic [ROB_ID_W-1:0] q2, input logic [XLEN-1:0] v2);
      disp_valid    = 1'b1;
      disp_optype   = op;
      disp_rd_alias = rd;
      disp_pc       = pc;
      disp_imm      = imm;
      disp_q1_busy  = b1;
      disp_q1       = q1;
      disp_v1       = v1;
      disp_q2_busy  = b2;
      disp_q2       = q2;
      disp_v2       = v2;
   endtask

   task automatic drive_cdb_alu(input logic [ROB_ID_W-1:0] a, input logic [XLEN-1:0] v);
      cdb_alu_valid = 1'b1;
      cdb_alu_alias = a;
      cdb_alu_value = v;
   endtask

   task automatic drive_cdb_lsb(input logic [ROB_ID_W-1:0] a, input logic [XLEN-1:0] v);
      cdb_lsb_valid = 1'b1;
      cdb_lsb_alias = a;
      cdb_lsb_value = v;
   endtask

   initial begin
      logic [XLEN-1:0] v2_tab [16];

      // Reset
      rst_in = 1'b0;
      rdy_in = 1'b1;
      idle_inputs();
      drive_disp(6'd0, 4'd0, '0, '0, 1'b0, 4'd0, '0, 1'b0, 4'd0, '0);
      disp_valid    = 1'b0;
      cdb_alu_alias = '0; cdb_alu_value = '0;
      cdb_lsb_alias = '0; cdb_lsb_value = '0;
      repeat (3) @(posedge clk_in);
      #1;
      check("rst_out", {alu_optype, alu_rd_alias, alu_pc, alu_rs1, alu_rs2, alu_imm}, '0);
      chk_full("rst_full", 1'b0);
      rst_in = 1'b1;

      // Both operands ready: issue one edge after dispatch
      drive_disp(OP_ADDI, 4'd2, 32'h100, 32'd3, 1'b0, 4'd0, 32'd5, 1'b0, 4'd0, 32'd0);
      exp_q.push_back(mk_pkt(OP_ADDI, 4'd2, 32'h100, 32'd5, 32'd0, 32'd3));
      step();
      chk_op("addi_not_yet", '0);
      disp_valid = 1'b0;
      step();
      chk_op("addi_issue", OP_ADDI);
      step();
      chk_op("addi_nop_after", '0);
      check("addi_rs1_hold", PKT_W'(alu_rs1), PKT_W'(32'd5));

      // rs1 pending, woken by ALU CDB two cycles later
      drive_disp(OP_ADD, 4'd5, 32'h200, 32'd0, 1'b1, 4'd7, 32'hBAD, 1'b0, 4'd0, 32'h22);
      step();
      disp_valid = 1'b0;
      step();
      chk_op("add_waiting", '0);
      drive_cdb_alu(4'd7, 32'h10);
      exp_q.push_back(mk_pkt(OP_ADD, 4'd5, 32'h200, 32'h10, 32'h22, 32'd0));
      step();
      chk_op("add_woken_no_issue", '0);
      cdb_alu_valid = 1'b0;
      step();
      chk_op("add_issue", OP_ADD);

      // rs2 pending, bypassed from LSB CDB in the dispatch cycle
      drive_disp(OP_SUB, 4'd6, 32'h300, 32'd0, 1'b0, 4'd0, 32'd1, 1'b1, 4'd4, 32'h0);
      drive_cdb_lsb(4'd4, 32'hDEAD);
      exp_q.push_back(mk_pkt(OP_SUB, 4'd6, 32'h300, 32'd1, 32'hDEAD, 32'd0));
      step();
      chk_op("sub_lat0", '0);
      idle_inputs();
      step();
      chk_op("sub_issue", OP_SUB);
      step();

      // rdy_in low holds dispatch
      rdy_in = 1'b0;
      drive_disp(OP_ADDI, 4'd1, 32'h500, 32'd9, 1'b0, 4'd0, 32'd7, 1'b0, 4'd0, 32'd0);
      step();
      chk_op("stall_nop0", '0);
      step();
      chk_op("stall_nop1", '0);
      rdy_in = 1'b1;
      exp_q.push_back(mk_pkt(OP_ADDI, 4'd1, 32'h500, 32'd7, 32'd0, 32'd9));
      step();
      disp_valid = 1'b0;
      step();
      chk_op("stall_issue", OP_ADDI);

      // CDB during rdy_in low is not captured
      drive_disp(OP_ADD, 4'd3, 32'h510, 32'd0, 1'b1, 4'd8, 32'd0, 1'b0, 4'd0, 32'd4);
      step();
      disp_valid = 1'b0;
      rdy_in = 1'b0;
      drive_cdb_alu(4'd8, 32'h88);
      step();
      rdy_in = 1'b1;
      cdb_alu_valid = 1'b0;
      step();
      chk_op("stall_cdb_nop0", '0);
      step();
      chk_op("stall_cdb_nop1", '0);
      drive_cdb_alu(4'd8, 32'h77);
      exp_q.push_back(mk_pkt(OP_ADD, 4'd3, 32'h510, 32'h77, 32'd4, 32'd0));
      step();
      cdb_alu_valid = 1'b0;
      step();
      chk_op("stall_cdb_issue", OP_ADD);

      // Fill all 16 entries with pending rs1
      for (int i = 0; i < 16; i++) begin
         v2_tab[i] = $urandom_range(0, 32'hFFFF);
         drive_disp(OP_OR, 4'(i), 32'h400 + 32'(i), 32'(i), 1'b1, 4'(i), 32'd0, 1'b0, 4'd0, v2_tab[i]);
         step();
         if (i == 14) chk_full("full_not_yet", 1'b0);
      end
      chk_full("full_set", 1'b1);
      drive_disp(OP_ADDI, 4'd15, 32'h999, 32'd1, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd1);
      step();
      chk_full("full_ignore", 1'b1);
      chk_op("full_ignore_nop", '0);
      disp_valid = 1'b0;
      drive_cdb_alu(4'd9, 32'h99);
      exp_q.push_back(mk_pkt(OP_OR, 4'd9, 32'h409, 32'h99, v2_tab[9], 32'd9));
      step();
      cdb_alu_valid = 1'b0;
      step();
      chk_op("full_wake_issue", OP_OR);
      chk_full("full_drop", 1'b0);
      for (int i = 0; i < 16; i++) begin
         if (i != 9) begin
            drive_cdb_alu(4'(i), 32'h1000 + 32'(i));
            exp_q.push_back(mk_pkt(OP_OR, 4'(i), 32'h400 + 32'(i), 32'h1000 + 32'(i),
                                   v2_tab[i], 32'(i)));
            step();
         end
      end
      cdb_alu_valid = 1'b0;
      step();
      step();
      check("drain_empty", PKT_W'(exp_q.size()), '0);

      // Flush drops entries and the same-cycle dispatch
      for (int i = 1; i <= 3; i++) begin
         drive_disp(OP_XOR, 4'(i), 32'h700 + 32'(i), 32'd0, 1'b1, 4'(i), 32'd0, 1'b0, 4'd0, 32'd0);
         step();
      end
      drive_disp(OP_ADDI, 4'd4, 32'h780, 32'd1, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd1);
      flush_in = 1'b1;
      step();
      chk_op("flush_nop", '0);
      chk_full("flush_full", 1'b0);
      idle_inputs();
      for (int i = 1; i <= 3; i++) begin
         drive_cdb_alu(4'(i), 32'h55);
         step();
      end
      cdb_alu_valid = 1'b0;
      step();
      step();
      chk_op("flush_no_issue", '0);

      // Issue order: A in slot 1, B in slot 0, woken together
      drive_disp(OP_XOR, 4'd10, 32'h600, 32'd0, 1'b1, 4'd10, 32'd0, 1'b0, 4'd0, 32'd0);
      step();
      drive_disp(OP_AND, 4'd11, 32'h610, 32'd0, 1'b1, 4'd11, 32'd0, 1'b0, 4'd0, 32'd0);
      step();
      disp_valid = 1'b0;
      drive_cdb_alu(4'd10, 32'hC);
      exp_q.push_back(mk_pkt(OP_XOR, 4'd10, 32'h600, 32'hC, 32'd0, 32'd0));
      step();
      cdb_alu_valid = 1'b0;
      step();
      chk_op("order_c_issue", OP_XOR);
      drive_disp(OP_SLT, 4'd12, 32'h620, 32'd0, 1'b1, 4'd12, 32'd0, 1'b0, 4'd0, 32'd0);
      step();
      disp_valid = 1'b0;
      drive_cdb_alu(4'd11, 32'hA);
      drive_cdb_lsb(4'd12, 32'hB);
`ifdef RS_ALU_OLDEST_FIRST_EN
      exp_q.push_back(mk_pkt(OP_AND, 4'd11, 32'h610, 32'hA, 32'd0, 32'd0));
      exp_q.push_back(mk_pkt(OP_SLT, 4'd12, 32'h620, 32'hB, 32'd0, 32'd0));
`else
      exp_q.push_back(mk_pkt(OP_SLT, 4'd12, 32'h620, 32'hB, 32'd0, 32'd0));
      exp_q.push_back(mk_pkt(OP_AND, 4'd11, 32'h610, 32'hA, 32'd0, 32'd0));
`endif
      step();
      idle_inputs();
      step();
`ifdef RS_ALU_OLDEST_FIRST_EN
      chk_op("order_first", OP_AND);
      step();
      chk_op("order_second", OP_SLT);
`else
      chk_op("order_first", OP_SLT);
      step();
      chk_op("order_second", OP_AND);
`endif
      step();
      chk_op("order_done_nop", '0);

      // Final report
      check("final_queue_empty", PKT_W'(exp_q.size()), '0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
